ddr_init_seq: RTL and testbench

DDR SDRAM power-up initialization sequencer. Runs from the 133 MHz memory clock and the reset released by the clock-generation block. After reset it drives the JEDEC DDR1 bring-up command sequence onto the SDRAM command/address pins, then asserts `initDone` and hands the pins to the memory controller. The controller muxes on `initDone`.

---
 rtl/ddr_init_seq.sv | 162 ++++++++++++++++
 tb/tb_ddr_init_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_seq.sv
// ddr_init_seq: DDR1 SDRAM power-up initialization sequencer.
// Holds CKE low for the power-up interval, then issues PRE, EMR, MR(DLL reset),
// PRE, AREF, AREF, MR with the configured spacing. It then waits for DLL lock
// and raises initDone, which stays high until the next reset.
module ddr_init_seq #(
   parameter int          POWERUP_CYCLES = 26600,
   parameter int          TRP            = 3,
   parameter int          TMRD           = 2,
   parameter int          TRFC           = 10,
   parameter int          DLL_CYCLES     = 200,
   parameter logic [12:0] MODE_REG       = 13'h021,
   parameter logic [12:0] EXT_MODE_REG   = 13'h000
) (
   input  logic        clk,
   input  logic        rstN,
   output logic        cke,
   output logic        csN,
   output logic        rasN,
   output logic        casN,
   output logic        weN,
   output logic [1:0]  ba,
   output logic [12:0] addr,
   output logic        initDone
);

   // The shared wait counter must hold the longest load value.
   localparam int MAX_A  = (POWERUP_CYCLES > DLL_CYCLES) ? POWERUP_CYCLES : DLL_CYCLES;
   localparam int MAX_B  = (TRP > TMRD) ? TRP : TMRD;
   localparam int MAX_C  = (MAX_B > TRFC) ? MAX_B : TRFC;
   localparam int MAXC   = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int CNT_W  = $clog2(MAXC + 1);

   // MR itself takes one cycle, so DLL_WAIT covers the remaining DLL_CYCLES-1.
   localparam int DLL_LD = (DLL_CYCLES > 1) ? DLL_CYCLES - 2 : 0;

   localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(POWERUP_CYCLES);
   localparam logic [CNT_W-1:0] LD_TRP  = CNT_W'(TRP - 1);
   localparam logic [CNT_W-1:0] LD_TMRD = CNT_W'(TMRD - 1);
   localparam logic [CNT_W-1:0] LD_TRFC = CNT_W'(TRFC - 1);
   localparam logic [CNT_W-1:0] LD_DLL  = CNT_W'(DLL_LD);

   // {csN,rasN,casN,weN}
   localparam logic [3:0] CMD_DESEL = 4'b1111;
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_AREF  = 4'b0001;
   localparam logic [3:0] CMD_LMR   = 4'b0000;

   localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;
   localparam logic [12:0] MR_DLL_ADDR  = MODE_REG | 13'h0100;

   typedef enum logic [3:0] {
      PWR_WAIT, CKE_NOP, PRE1, EMR, MR_DLL, PRE2,
      AREF1, AREF2, MR, DLL_WAIT, DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cke_q, cke_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [1:0]        ba_q, ba_d;
   logic [12:0]       addr_q, addr_d;
   logic              done_q, done_d;

   // Successor of each state; MR skips DLL_WAIT when the DLL wait is one cycle.
   function automatic state_t next_state(input state_t s);
      case (s)
         PWR_WAIT: next_state = CKE_NOP;
         CKE_NOP:  next_state = PRE1;
         PRE1:     next_state = EMR;
         EMR:      next_state = MR_DLL;
         MR_DLL:   next_state = PRE2;
         PRE2:     next_state = AREF1;
         AREF1:    next_state = AREF2;
         AREF2:    next_state = MR;
         MR:       next_state = (DLL_CYCLES > 1) ? DLL_WAIT : DONE;
         default:  next_state = DONE;
      endcase
   endfunction

   // Extra NOP cycles to hold each state after its entry cycle.
   function automatic logic [CNT_W-1:0] gap_load(input state_t s);
      case (s)
         PRE1, PRE2:    gap_load = LD_TRP;
         EMR, MR_DLL:   gap_load = LD_TMRD;
         AREF1, AREF2:  gap_load = LD_TRFC;
         DLL_WAIT:      gap_load = LD_DLL;
         default:       gap_load = '0;
      endcase
   endfunction

   // State register, wait counter and registered pin drivers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= PWR_WAIT;
         cnt_q   <= LD_PWR;
         cke_q   <= 1'b0;
         cmd_q   <= CMD_DESEL;
         ba_q    <= 2'b00;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cke_q   <= cke_d;
         cmd_q   <= cmd_d;
         ba_q    <= ba_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   // Advance when the counter expires; a command is driven only in the entry cycle of its state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = CMD_NOP;
      ba_d    = 2'b00;
      addr_d  = '0;
      if (state_q != DONE) begin
         if (cnt_q == '0) begin
            state_d = next_state(state_q);
            cnt_d   = gap_load(state_d);
            case (state_d)
               PRE1, PRE2: begin
                  cmd_d  = CMD_PRE;
                  addr_d = PRE_ALL_ADDR;
               end
               EMR: begin
                  cmd_d  = CMD_LMR;
                  ba_d   = 2'b01;
                  addr_d = EXT_MODE_REG;
               end
               MR_DLL: begin
                  cmd_d  = CMD_LMR;
                  addr_d = MR_DLL_ADDR;
               end
               AREF1, AREF2: cmd_d = CMD_AREF;
               MR: begin
                  cmd_d  = CMD_LMR;
                  addr_d = MODE_REG;
               end
               default: ;
            endcase
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
      cke_d  = (state_d != PWR_WAIT);
      done_d = (state_d == DONE);
   end

   assign cke      = cke_q;
   assign csN      = cmd_q[3];
   assign rasN     = cmd_q[2];
   assign casN     = cmd_q[1];
   assign weN      = cmd_q[0];
   assign ba       = ba_q;
   assign addr     = addr_q;
   assign initDone = done_q;

endmodule

// File: tb/tb_ddr_init_seq.sv
// tb_ddr_init_seq: scoreboard bench for ddr_init_seq.
// Instance A uses the nominal bench timing, instance B the minimum spacing.
module tb_ddr_init_seq;

   typedef struct packed {
      logic        cke;
      logic [3:0]  cmd;
      logic [1:0]  ba;
      logic [12:0] addr;
      logic        done;
   } obs_t;

   localparam obs_t RST_VAL = '{cke: 1'b0, cmd: 4'b1111, ba: 2'b00, addr: 13'h0, done: 1'b0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstN_a, rstN_b;
   logic        cke_a, csN_a, rasN_a, casN_a, weN_a, done_a;
   logic [1:0]  ba_a;
   logic [12:0] addr_a;
   logic        cke_b, csN_b, rasN_b, casN_b, weN_b, done_b;
   logic [1:0]  ba_b;
   logic [12:0] addr_b;

   ddr_init_seq #(.POWERUP_CYCLES(4), .TRP(2), .TMRD(2), .TRFC(3), .DLL_CYCLES(5)) u_a (
      .clk(clk), .rstN(rstN_a), .cke(cke_a), .csN(csN_a), .rasN(rasN_a), .casN(casN_a),
      .weN(weN_a), .ba(ba_a), .addr(addr_a), .initDone(done_a));

   ddr_init_seq #(.POWERUP_CYCLES(1), .TRP(1), .TMRD(1), .TRFC(1), .DLL_CYCLES(1)) u_b (
      .clk(clk), .rstN(rstN_b), .cke(cke_b), .csN(csN_b), .rasN(rasN_b), .casN(casN_b),
      .weN(weN_b), .ba(ba_b), .addr(addr_b), .initDone(done_b));

   obs_t sb[$];
   int   passed = 0;
   int   total  = 0;

   function automatic obs_t get_obs(input bit sel);
      obs_t o;
      if (sel) o = '{cke_b, {csN_b, rasN_b, casN_b, weN_b}, ba_b, addr_b, done_b};
      else     o = '{cke_a, {csN_a, rasN_a, casN_a, weN_a}, ba_a, addr_a, done_a};
      return o;
   endfunction

   // Expected pins in cycle k, built from the documented issue-cycle offsets.
   function automatic obs_t exp_at(input int k, input int p, input int trp, input int tmrd,
                                   input int trfc, input int dll);
      obs_t e;
      int pre1, emr, mrd, pre2, a1, a2, lmr;
      pre1 = p + 1;
      emr  = pre1 + trp;
      mrd  = emr + tmrd;
      pre2 = mrd + tmrd;
      a1   = pre2 + trp;
      a2   = a1 + trfc;
      lmr  = a2 + trfc;
      e = '{cke: (k >= p), cmd: 4'b0111, ba: 2'b00, addr: 13'h0, done: (k >= lmr + dll)};
      if (k == pre1 || k == pre2) begin
         e.cmd = 4'b0010; e.addr = 13'h0400;
      end else if (k == emr) begin
         e.cmd = 4'b0000; e.ba = 2'b01; e.addr = 13'h0000;
      end else if (k == mrd) begin
         e.cmd = 4'b0000; e.addr = 13'h0121;
      end else if (k == a1 || k == a2) begin
         e.cmd = 4'b0001;
      end else if (k == lmr) begin
         e.cmd = 4'b0000; e.addr = 13'h0021;
      end
      return e;
   endfunction

   // Release reset on a falling edge, then score cycles 0..ncyc-1 and count commands seen.
   task automatic run_seq(input bit sel, input int p, input int trp, input int tmrd,
                          input int trfc, input int dll, input int ncyc, input string name,
                          output int ncmd);
      obs_t got, e;
      ncmd = 0;
      @(negedge clk);
      for (int k = 0; k < ncyc; k++) sb.push_back(exp_at(k, p, trp, tmrd, trfc, dll));
      if (sel) rstN_b = 1'b1; else rstN_a = 1'b1;
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk);
         #1;
         got = get_obs(sel);
         e   = sb.pop_front();
         if (got.cmd != 4'b0111 && got.cmd != 4'b1111) ncmd++;
         total++;
         if (got !== e)
            $display("FAIL %s cycle %0d: got cke=%b cmd=%b ba=%h addr=%h done=%b, want cke=%b cmd=%b ba=%h addr=%h done=%b",
                     name, k, got.cke, got.cmd, got.ba, got.addr, got.done,
                     e.cke, e.cmd, e.ba, e.addr, e.done);
         else passed++;
      end
   endtask

   task automatic check_rst(input bit sel, input string name);
      obs_t got;
      got = get_obs(sel);
      total++;
      if (got !== RST_VAL)
         $display("FAIL %s: got %h, want %h", name, got, RST_VAL);
      else passed++;
   endtask

   task automatic test_reset;
      rstN_a = 1'b0;
      rstN_b = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_rst(1'b0, "reset_a");
         check_rst(1'b1, "reset_b");
      end
   endtask

   task automatic test_full_sequence;
      int n;
      run_seq(1'b0, 4, 2, 2, 3, 5, 125, "full_seq", n);
      total++;
      if (n !== 7) $display("FAIL cmd_count: got %0d commands, want 7", n);
      else passed++;
   endtask

   task automatic test_mid_reset;
      int n;
      rstN_a = 1'b0;
      repeat (2) @(posedge clk);
      run_seq(1'b0, 4, 2, 2, 3, 5, 13, "pre_mid_reset", n);
      #2 rstN_a = 1'b0;
      #1 check_rst(1'b0, "mid_reset_async");
      repeat (2) @(posedge clk);
      #1 check_rst(1'b0, "mid_reset_held");
      run_seq(1'b0, 4, 2, 2, 3, 5, 30, "replay", n);
      total++;
      if (n !== 7) $display("FAIL replay_count: got %0d commands, want 7", n);
      else passed++;
   endtask

   task automatic test_done_reset;
      int n;
      total++;
      if (done_a !== 1'b1) $display("FAIL done_before_reset: got %b, want 1", done_a);
      else passed++;
      #2 rstN_a = 1'b0;
      #1;
      total++;
      if (done_a !== 1'b0) $display("FAIL done_drop: got %b, want 0", done_a);
      else passed++;
      check_rst(1'b0, "done_reset_async");
      @(posedge clk);
      run_seq(1'b0, 4, 2, 2, 3, 5, 40, "after_done_reset", n);
   endtask

   task automatic test_min_spacing;
      int n;
      run_seq(1'b1, 1, 1, 1, 1, 1, 30, "min_spacing", n);
      total++;
      if (n !== 7) $display("FAIL min_count: got %0d commands, want 7", n);
      else passed++;
   endtask

   initial begin
      rstN_a = 1'b0;
      rstN_b = 1'b0;
      test_reset();
      test_full_sequence();
      test_mid_reset();
      test_done_reset();
      test_min_spacing();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
      $fatal(1);
   end

endmodule
